// File: rtl/mod_n_counter.sv
// Cascadable modulo-N digit counter: up/down count, synchronous clear and
// range-checked load, zero-latency carry/borrow (ce), registered WRAP/ERR pulses.
module mod_n_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             INC,
  input  logic             DOWN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             ce,
  output logic             WRAP,
  output logic             ERR
);

  generate
    if (MODULUS < 2 || (2 ** WIDTH) < MODULUS) begin : g_bad_params
      $error("mod_n_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic terminal;

  assign terminal = DOWN ? (Q == '0) : (Q == MAX_Q);

  // Carry leaves in the same cycle so the next digit steps on the wrap edge.
  assign ce = INC & ~CLR & ~LOAD & Reset_n & terminal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the pulse defaults at the top give one-cycle flags.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Q    <= '0;
      WRAP <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      ERR  <= 1'b0;
      if (CLR) begin
        Q <= '0;
      end else if (LOAD) begin
        if (LOAD_VAL <= MAX_Q) Q <= LOAD_VAL;
        else                   ERR <= 1'b1;
      end else if (INC) begin
        if (Q > MAX_Q) begin
          // Recovery from an out-of-range value: no wrap reported.
          Q <= '0;
        end else if (!DOWN) begin
          if (Q == MAX_Q) begin
            Q    <= '0;
            WRAP <= 1'b1;
          end else begin
            Q <= Q + 1'b1;
          end
        end else begin
          if (Q == '0) begin
            Q    <= MAX_Q;
            WRAP <= 1'b1;
          end else begin
            Q <= Q - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed scenarios plus randomized
// traffic against an integer reference model; a mod-10/mod-6 cascade pair.
module tb_mod_n_counter;

  localparam int M = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0, down = 1'b0, clr = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] q;
  logic       ce, wrap, err;

  logic       u_inc = 1'b0;
  logic [3:0] u_q;
  logic       u_ce, u_wrap, u_err;
  logic [2:0] t_q;
  logic       t_ce, t_wrap, t_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: the count as a plain integer plus pending flags.
  int m_q    = 0;
  bit m_wrap = 0;
  bit m_err  = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.MODULUS(6), .WIDTH(3)) dut (
    .CLK(clk), .Reset_n(rst_n), .INC(inc), .DOWN(down), .CLR(clr), .LOAD(load),
    .LOAD_VAL(load_val), .Q(q), .ce(ce), .WRAP(wrap), .ERR(err)
  );

  mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_units (
    .CLK(clk), .Reset_n(rst_n), .INC(u_inc), .DOWN(1'b0), .CLR(1'b0), .LOAD(1'b0),
    .LOAD_VAL(4'd0), .Q(u_q), .ce(u_ce), .WRAP(u_wrap), .ERR(u_err)
  );

  mod_n_counter #(.MODULUS(6), .WIDTH(3)) u_tens (
    .CLK(clk), .Reset_n(rst_n), .INC(u_ce), .DOWN(1'b0), .CLR(1'b0), .LOAD(1'b0),
    .LOAD_VAL(3'd0), .Q(t_q), .ce(t_ce), .WRAP(t_wrap), .ERR(t_err)
  );

  function automatic bit model_ce();
    if (!inc || clr || load || !rst_n) return 1'b0;
    return down ? (m_q == 0) : (m_q == M - 1);
  endfunction

  // Apply the counter rules to the model for the inputs currently driven.
  function automatic void model_step();
    m_wrap = 0;
    m_err  = 0;
    if (clr) begin
      m_q = 0;
    end else if (load) begin
      if (int'(load_val) < M) m_q = int'(load_val);
      else m_err = 1;
    end else if (inc) begin
      if (!down) begin
        m_wrap = (m_q == M - 1);
        m_q    = (m_q + 1) % M;
      end else begin
        m_wrap = (m_q == 0);
        m_q    = (m_q + M - 1) % M;
      end
    end
  endfunction

  function automatic logic [4:0] model_vec();
    return {3'(m_q), m_wrap, m_err};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit i, input bit d, input bit c, input bit l, input logic [2:0] v);
    inc = i; down = d; clr = c; load = l; load_val = v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 3'd0);
    m_q = 0; m_wrap = 0; m_err = 0;
    total++;
    if ({q, wrap, err, ce} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state: got q=%0d wrap=%b err=%b ce=%b want all 0", q, wrap, err, ce);
    end
    drive(0, 0, 0, 0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up_wrap();
    int exp_seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    total++;
    if (q !== 3'd0) begin
      bad++;
      $display("FAIL up_start: got q=%0d want 0", q);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 3'd0);
      total++;
      if (ce !== (exp_seq[i] == 5)) begin
        bad++;
        $display("FAIL up_ce: step %0d got ce=%b with q=%0d", i, ce, q);
      end
      tick();
      total++;
      if (q !== 3'(exp_seq[i+1]) || wrap !== (i == 5) || {q, wrap, err} !== model_vec()) begin
        bad++;
        $display("FAIL up_step: step %0d got q=%0d wrap=%b want q=%0d wrap=%b", i, q, wrap, exp_seq[i+1], i == 5);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp_seq[4] = '{1, 0, 5, 4};
    drive(0, 0, 0, 1, 3'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 3'd0);
      total++;
      if (ce !== (exp_seq[i] == 0)) begin
        bad++;
        $display("FAIL down_ce: step %0d got ce=%b with q=%0d", i, ce, q);
      end
      tick();
      total++;
      if (q !== 3'(exp_seq[i+1]) || wrap !== (i == 1) || {q, wrap, err} !== model_vec()) begin
        bad++;
        $display("FAIL down_step: step %0d got q=%0d wrap=%b want q=%0d wrap=%b", i, q, wrap, exp_seq[i+1], i == 1);
      end
    end
  endtask

  task automatic test_load_range();
    logic [2:0] vals[3] = '{3'd4, 3'd7, 3'd6};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, vals[i]);
      total++;
      if (ce !== 1'b0) begin
        bad++;
        $display("FAIL load_ce: got ce=%b want 0", ce);
      end
      tick();
      total++;
      if (q !== 3'd4 || err !== (i != 0) || wrap !== 1'b0) begin
        bad++;
        $display("FAIL load_%0d: got q=%0d err=%b wrap=%b want q=4 err=%b wrap=0", vals[i], q, err, wrap, i != 0);
      end
    end
    drive(0, 0, 0, 0, 3'd0);
    tick();
    total++;
    if (err !== 1'b0 || q !== 3'd4) begin
      bad++;
      $display("FAIL load_err_clear: got err=%b q=%0d want err=0 q=4", err, q);
    end
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 1, 3'd5);
    tick();
    drive(1, 0, 1, 1, 3'd3);
    total++;
    if (ce !== 1'b0) begin
      bad++;
      $display("FAIL prio_ce: got ce=%b want 0 at q=5 with clr", ce);
    end
    tick();
    total++;
    if ({q, wrap, err} !== 5'b000_0_0) begin
      bad++;
      $display("FAIL prio_clr: got q=%0d wrap=%b err=%b want q=0 wrap=0 err=0", q, wrap, err);
    end
    drive(1, 0, 0, 1, 3'd3);
    tick();
    total++;
    if ({q, wrap, err} !== 5'b011_0_0) begin
      bad++;
      $display("FAIL prio_load: got q=%0d wrap=%b err=%b want q=3", q, wrap, err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
            $urandom_range(15, 0) == 0, $urandom_range(5, 0) == 0,
            3'($urandom_range(7, 0)));
      total++;
      if (ce !== model_ce()) begin
        bad++;
        $display("FAIL rand_ce: cycle %0d got ce=%b want %b (q=%0d)", i, ce, model_ce(), q);
      end
      tick();
      total++;
      if ({q, wrap, err} !== model_vec() || (wrap && err)) begin
        bad++;
        $display("FAIL rand_state: cycle %0d got q=%0d wrap=%b err=%b want q=%0d wrap=%b err=%b",
                 i, q, wrap, err, m_q, m_wrap, m_err);
      end
    end
    drive(0, 0, 0, 0, 3'd0);
  endtask

  task automatic test_cascade();
    int n = 0;
    u_inc = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      total++;
      if (u_q !== 4'(n % 10) || t_q !== 3'(n / 10) || t_ce !== (n == 59)) begin
        bad++;
        $display("FAIL cascade: step %0d got %0d%0d t_ce=%b want %0d%0d t_ce=%b",
                 i, t_q, u_q, t_ce, n / 10, n % 10, n == 59);
      end
      @(posedge clk);
      #1;
      n = (n + 1) % 60;
    end
    u_inc = 1'b0;
    total++;
    if (u_q !== 4'd0 || t_q !== 3'd0 || t_wrap !== 1'b1 || u_wrap !== 1'b1) begin
      bad++;
      $display("FAIL cascade_rollover: got %0d%0d wraps=%b%b want 00 wraps=11", t_q, u_q, t_wrap, u_wrap);
    end
  endtask

  // Each pass sets up a different in-flight condition, then drops reset mid-cycle.
  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(0, 0, 0, 1, 3'd3);
        1: drive(0, 0, 0, 1, 3'd5);
        default: drive(0, 0, 0, 0, 3'd0);
      endcase
      tick();
      case (k)
        0: drive(1, 0, 0, 0, 3'd0);
        1: drive(1, 0, 0, 0, 3'd0);
        default: drive(0, 0, 0, 1, 3'd7);
      endcase
      if (k != 0) tick();
      if (k == 0) drive(1, 0, 0, 0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      m_q = 0; m_wrap = 0; m_err = 0;
      total++;
      if ({q, wrap, err, ce} !== 6'b0) begin
        bad++;
        $display("FAIL async_reset_%0d: got q=%0d wrap=%b err=%b ce=%b want all 0", k, q, wrap, err, ce);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 3'd0);
      tick();
      total++;
      if ({q, wrap, err} !== 5'b001_0_0) begin
        bad++;
        $display("FAIL async_release_%0d: got q=%0d wrap=%b err=%b want q=1", k, q, wrap, err);
      end
    end
    drive(0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_range();
    test_priority();
    test_random();
    test_cascade();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
